// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between a set of requesters, the burst arbiter and the FIFO write port.
// The arbiter takes the slave view; the requester/FIFO side takes the master view.
interface fifo_write_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 8
);
  localparam int IW = $clog2(REQUESTERS);

  logic [REQUESTERS-1:0]       request;
  logic [REQUESTERS*WIDTH-1:0] request_data;
  logic [REQUESTERS-1:0]       grant;
  logic                        fifo_full;
  logic                        fifo_write_enable;
  logic [WIDTH-1:0]            fifo_write_data;
  logic                        owner_valid;
  logic [IW-1:0]               owner_index;

  modport master (
    output request, request_data, fifo_full,
    input  grant, fifo_write_enable, fifo_write_data, owner_valid, owner_index
  );

  modport slave (
    input  request, request_data, fifo_full,
    output grant, fifo_write_enable, fifo_write_data, owner_valid, owner_index
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin FIFO write arbiter with burst ownership: an owner keeps the write port for up to
// MAX_BURST granted beats, and dropping its request hands the port on in the same cycle.
module fifo_write_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                 clock,
  input logic                 reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(REQUESTERS);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e                state_r;
  state_e                state_n_s;
  logic [IW-1:0]         ptr_r;
  logic [IW-1:0]         ptr_n_s;
  logic [IW-1:0]         owner_r;
  logic [IW-1:0]         owner_n_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_n_s;
  logic [CW-1:0]         count_inc_s;
  logic                  owner_valid_r;
  logic [IW-1:0]         arb_base_s;
  logic [IW-1:0]         arb_idx_s;
  logic                  arb_found_s;
  logic                  take_s;
  logic                  sel_valid_s;
  logic [IW-1:0]         sel_idx_s;
  logic [REQUESTERS-1:0] grant_s;
  logic [WIDTH-1:0]      data_s;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    if (p == IW'(REQUESTERS - 1)) begin
      return {IW{1'b0}};
    end else begin
      return p + IW'(1'b1);
    end
  endfunction

  // Round-robin search; a releasing owner searches from the slot just after itself.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = {IW{1'b0}};
    if (state_r == OWNED) begin
      arb_base_s = ptr_inc(owner_r);
    end else begin
      arb_base_s = ptr_r;
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      int            sum;
      logic [IW-1:0] cand;
      sum  = int'(arb_base_s) + i;
      cand = IW'((sum >= REQUESTERS) ? (sum - REQUESTERS) : sum);
      if (bus.request[cand] && !arb_found_s) begin
        arb_found_s = 1'b1;
        arb_idx_s   = cand;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Next-state and grant selection; full or reset freezes everything.
  always_comb begin
    state_n_s   = state_r;
    ptr_n_s     = ptr_r;
    owner_n_s   = owner_r;
    count_n_s   = count_r;
    count_inc_s = count_r + CW'(1'b1);
    sel_valid_s = 1'b0;
    sel_idx_s   = {IW{1'b0}};
    take_s      = 1'b0;
    if (reset || bus.fifo_full) begin
      take_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          take_s = arb_found_s;
        end
        OWNED: begin
          if (bus.request[owner_r]) begin
            sel_valid_s = 1'b1;
            sel_idx_s   = owner_r;
            count_n_s   = count_inc_s;
            if (count_inc_s == CW'(MAX_BURST)) begin
              ptr_n_s   = ptr_inc(owner_r);
              state_n_s = IDLE;
              owner_n_s = {IW{1'b0}};
            end else begin
              state_n_s = OWNED;
            end
          end else begin
            ptr_n_s   = ptr_inc(owner_r);
            state_n_s = IDLE;
            owner_n_s = {IW{1'b0}};
            take_s    = arb_found_s;
          end
        end
        default: begin
          state_n_s = IDLE;
        end
      endcase
    end

    if (take_s) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = arb_idx_s;
      count_n_s   = CW'(1'b1);
      if (MAX_BURST == 32'sd1) begin
        ptr_n_s   = ptr_inc(arb_idx_s);
        state_n_s = IDLE;
        owner_n_s = {IW{1'b0}};
      end else begin
        owner_n_s = arb_idx_s;
        state_n_s = OWNED;
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // One-hot grant and the matching data slice.
  always_comb begin
    grant_s = {REQUESTERS{1'b0}};
    data_s  = {WIDTH{1'b0}};
    for (int i = 0; i < REQUESTERS; i++) begin
      if (sel_valid_s && (sel_idx_s == IW'(i))) begin
        grant_s[i] = 1'b1;
        data_s     = bus.request_data[i*WIDTH +: WIDTH];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Arbiter state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      ptr_r         <= {IW{1'b0}};
      owner_r       <= {IW{1'b0}};
      count_r       <= {CW{1'b0}};
      owner_valid_r <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      ptr_r         <= ptr_n_s;
      owner_r       <= owner_n_s;
      count_r       <= count_n_s;
      owner_valid_r <= (state_n_s == OWNED);
    end
  end

  assign bus.grant             = grant_s;
  assign bus.fifo_write_enable = |(grant_s & bus.request);
  assign bus.fifo_write_data   = data_s;
  assign bus.owner_valid       = owner_valid_r;
  assign bus.owner_index       = owner_r;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench: three arbiters (MAX_BURST 4, 2, 1) with four 8-bit requesters each,
// checked with immediate assertions against hand-computed grants, data and ownership.
module tb_fifo_write_arbiter;
  logic clock;
  logic reset;
  int   n_asserts = 0;
  int   n_fail    = 0;

  fifo_write_arbiter_if #(.REQUESTERS(4), .WIDTH(8)) bus_a ();
  fifo_write_arbiter_if #(.REQUESTERS(4), .WIDTH(8)) bus_b ();
  fifo_write_arbiter_if #(.REQUESTERS(4), .WIDTH(8)) bus_c ();

  fifo_write_arbiter #(.REQUESTERS(4), .WIDTH(8), .MAX_BURST(4)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  fifo_write_arbiter #(.REQUESTERS(4), .WIDTH(8), .MAX_BURST(2)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));
  fifo_write_arbiter #(.REQUESTERS(4), .WIDTH(8), .MAX_BURST(1)) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] exp_data(input logic [3:0] g);
    case (g)
      4'b0001: return 8'h11;
      4'b0010: return 8'h22;
      4'b0100: return 8'h33;
      4'b1000: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int unit, input logic [3:0] req, input logic full);
    case (unit)
      0: begin bus_a.request = req; bus_a.fifo_full = full; end
      1: begin bus_b.request = req; bus_b.fifo_full = full; end
      default: begin bus_c.request = req; bus_c.fifo_full = full; end
    endcase
  endtask

  task automatic observe(input int unit, output logic [3:0] g, output logic we,
                         output logic [7:0] d, output logic ov, output logic [1:0] oi);
    case (unit)
      0: begin g = bus_a.grant; we = bus_a.fifo_write_enable; d = bus_a.fifo_write_data;
               ov = bus_a.owner_valid; oi = bus_a.owner_index; end
      1: begin g = bus_b.grant; we = bus_b.fifo_write_enable; d = bus_b.fifo_write_data;
               ov = bus_b.owner_valid; oi = bus_b.owner_index; end
      default: begin g = bus_c.grant; we = bus_c.fifo_write_enable; d = bus_c.fifo_write_data;
               ov = bus_c.owner_valid; oi = bus_c.owner_index; end
    endcase
  endtask

  // One clock: apply inputs, check the combinational outputs mid-cycle, cross the edge.
  task automatic beat(input int unit, input string tag, input logic [3:0] req,
                      input logic full, input logic [3:0] exp_g);
    logic [3:0] g; logic we; logic [7:0] d; logic ov; logic [1:0] oi;
    drive(unit, req, full);
    #4;
    observe(unit, g, we, d, ov, oi);
    check({tag, "_grant"}, 32'(g), 32'(exp_g));
    check({tag, "_we"}, 32'(we), 32'(|exp_g));
    check({tag, "_data"}, 32'(d), 32'(exp_data(exp_g)));
    @(posedge clock);
    #1;
  endtask

  task automatic owner(input int unit, input string tag, input logic ev, input logic [1:0] ei);
    logic [3:0] g; logic we; logic [7:0] d; logic ov; logic [1:0] oi;
    observe(unit, g, we, d, ov, oi);
    check({tag, "_ovalid"}, 32'(ov), 32'(ev));
    check({tag, "_oindex"}, 32'(oi), 32'(ei));
  endtask

  logic [3:0] exp_b [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                             4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
  logic [3:0] exp_c [6]  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};

  initial begin
    reset = 1'b1;
    bus_a.request_data = 32'h44332211;
    bus_b.request_data = 32'h44332211;
    bus_c.request_data = 32'h44332211;
    drive(0, 4'b0000, 1'b0);
    drive(1, 4'b0000, 1'b0);
    drive(2, 4'b0000, 1'b0);
    @(posedge clock);
    #1;

    // Reset: no grant with everything requesting, ownership cleared afterwards.
    beat(0, "rst", 4'b1111, 1'b0, 4'b0000);
    reset = 1'b0;
    drive(0, 4'b0000, 1'b0);
    owner(0, "rst_a", 1'b0, 2'd0);
    owner(1, "rst_b", 1'b0, 2'd0);
    owner(2, "rst_c", 1'b0, 2'd0);

    // Lone requester 1: four-beat burst, release to pointer 2, then re-granted.
    beat(0, "solo_c1", 4'b0010, 1'b0, 4'b0010);
    owner(0, "solo_c1", 1'b1, 2'd1);
    beat(0, "solo_c2", 4'b0010, 1'b0, 4'b0010);
    beat(0, "solo_c3", 4'b0010, 1'b0, 4'b0010);
    beat(0, "solo_c4", 4'b0010, 1'b0, 4'b0010);
    owner(0, "solo_rel", 1'b0, 2'd0);
    beat(0, "solo_c5", 4'b0010, 1'b0, 4'b0010);
    owner(0, "solo_c5", 1'b1, 2'd1);
    beat(0, "solo_c6", 4'b0010, 1'b0, 4'b0010);
    beat(0, "solo_drop", 4'b0000, 1'b0, 4'b0000);
    owner(0, "solo_drop", 1'b0, 2'd0);

    // Owner 0 stalls on full at count 2, finishes two more beats, then releases.
    beat(0, "stall_b1", 4'b0001, 1'b0, 4'b0001);
    beat(0, "stall_b2", 4'b0001, 1'b0, 4'b0001);
    owner(0, "stall_b2", 1'b1, 2'd0);
    beat(0, "stall_f1", 4'b0001, 1'b1, 4'b0000);
    beat(0, "stall_f2", 4'b0001, 1'b1, 4'b0000);
    beat(0, "stall_f3", 4'b0001, 1'b1, 4'b0000);
    owner(0, "stall_full", 1'b1, 2'd0);
    beat(0, "stall_b3", 4'b0001, 1'b0, 4'b0001);
    owner(0, "stall_b3", 1'b1, 2'd0);
    beat(0, "stall_b4", 4'b0001, 1'b0, 4'b0001);
    owner(0, "stall_rel", 1'b0, 2'd0);
    beat(0, "stall_new", 4'b0001, 1'b0, 4'b0001);
    owner(0, "stall_new", 1'b1, 2'd0);
    beat(0, "stall_drop", 4'b0000, 1'b0, 4'b0000);
    beat(0, "idle_full", 4'b0100, 1'b1, 4'b0000);
    owner(0, "idle_full", 1'b0, 2'd0);

    // Owner 2 ignores requester 0, then drops: same-cycle hand-off via pointer 3 wrap.
    beat(0, "hand_o2", 4'b0100, 1'b0, 4'b0100);
    owner(0, "hand_o2", 1'b1, 2'd2);
    beat(0, "hand_ign", 4'b0101, 1'b0, 4'b0100);
    beat(0, "hand_off", 4'b0001, 1'b0, 4'b0001);
    owner(0, "hand_off", 1'b1, 2'd0);

    // Reset in the middle of owner 3's burst.
    beat(0, "mid_drop", 4'b0000, 1'b0, 4'b0000);
    beat(0, "mid_o3a", 4'b1000, 1'b0, 4'b1000);
    beat(0, "mid_o3b", 4'b1000, 1'b0, 4'b1000);
    owner(0, "mid_o3", 1'b1, 2'd3);
    reset = 1'b1;
    beat(0, "mid_rst", 4'b1111, 1'b0, 4'b0000);
    reset = 1'b0;
    owner(0, "mid_rst", 1'b0, 2'd0);
    beat(0, "mid_after", 4'b1111, 1'b0, 4'b0001);
    owner(0, "mid_after", 1'b1, 2'd0);
    beat(0, "mid_idle", 4'b0000, 1'b0, 4'b0000);

    // MAX_BURST 2, all requesting: pairs of grants rotating with wrap.
    for (int i = 0; i < 10; i++) begin
      beat(1, $sformatf("rr2_%0d", i), 4'b1111, 1'b0, exp_b[i]);
    end

    // MAX_BURST 1, requesters 0 and 2: strict alternation, never owned.
    for (int i = 0; i < 6; i++) begin
      beat(2, $sformatf("mb1_%0d", i), 4'b0101, 1'b0, exp_c[i]);
      owner(2, $sformatf("mb1_%0d", i), 1'b0, 2'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
